spi_mem_bridge: RTL and testbench
=================================

Name: spi_mem_bridge

Overview:
- SPI slave (mode 0, MSB first) front end that sits directly upstream of the 256-bit DFF memory (32 x 8 bits).
- Converts host SPI transactions into single-cycle byte write and read strobes on the memory's byte port.
- Returns read data on MISO; auto-increments the address within a transaction.
- All SPI pins are oversampled in the clk domain; there are no sclk-clocked flops.

Parameters:
- ADDR_W, 5, memory address width (32 bytes).
- DATA_W, 8, byte width; the command word is also DATA_W bits.
- SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and mosi.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_sclk  input  1  SPI clock, idle low.
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  host-to-block data.
- spi_miso  output  1  block-to-host data.
- spi_miso_oe  output  1  MISO drive enable; high while cs is active.
- mem_addr  output  ADDR_W  byte address to memory.
- mem_wdata  output  DATA_W  write data.
- mem_we  output  1  one-cycle write strobe.
- mem_re  output  1  one-cycle read strobe.
- mem_rdata  input  DATA_W  read data; valid the cycle after mem_re.
- busy  output  1  high from cs active to cs inactive.

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low rst_n.
  - All outputs and registers are 0 on reset: mem_addr, mem_wdata, mem_we, mem_re, spi_miso, spi_miso_oe, busy.
  - State is IDLE.
  - Assertion mid-transaction aborts it; no strobe is issued.
- Synchronisers: sclk, cs_n and mosi pass through SYNC_STAGES flops.
  - Rise and fall events are each a single clk cycle, taken from the synchronised sclk.
  - mosi is sampled on rise events.
- IDLE:
  - Synchronised cs_n low -> CMD; bit count = 0; busy = 1; spi_miso_oe = 1.
- CMD: shift in 8 bits.
  - On the 8th rise: mem_addr <= cmd[ADDR_W-1:0]. cmd[6:5] are ignored.
  - cmd[7] = 1 -> WRITE.
  - cmd[7] = 0 -> FETCH, with mem_re pulsed that cycle.
- WRITE:
  - Each completed byte: mem_wdata <= byte and mem_we = 1 for exactly one cycle, in the cycle after the 8th rise.
  - The cycle after the strobe: mem_addr increments.
- FETCH:
  - Cycle after mem_re: load tx shift register from mem_rdata; -> SHIFT.
- SHIFT:
  - spi_miso = tx[DATA_W-1] at all times.
  - On fall events with bit count != 0: tx shifts left, filling with 0.
  - Rise events count bits.
  - On the 8th rise: mem_addr increments and mem_re pulses in the same cycle -> FETCH.
  - The reload lands before the next fall, so the next byte's MSB is valid for the first rise of that byte.
- Address wrap: 31 + 1 -> 0 in both read and write. There is no end-of-memory error.
- cs_n deassert (synchronised), in any state:
  - -> IDLE next cycle.
  - A partial byte is discarded; no mem_we for fewer than 8 bits.
  - busy = 0, spi_miso_oe = 0, spi_miso = 0.
  - mem_addr holds its last value.
- Strobe exclusivity:
  - mem_we and mem_re are never high in the same cycle.
  - Each strobe is high for at most one consecutive cycle.
- Transactions: a new transaction always starts with a command byte. Back-to-back cs cycles with >= 2 clk of cs high are supported.
- sclk edges while cs_n is high are ignored.

Test Plan:
- Write single byte: cs low, send 0x83, 0xA5, cs high -> exactly one mem_we with mem_addr=3, mem_wdata=0xA5; memory byte 3 reads back 0xA5.
- Burst write with wrap: cmd 0x9E (addr 30), data 0x11, 0x22, 0x33 -> writes 30=0x11, 31=0x22, 0=0x33; three mem_we pulses.
- Read burst: preload bytes 4 and 5 = 0x5A, 0xC3; send 0x04 then 16 dummy clocks -> MISO yields 0x5A, 0xC3; mem_re pulses at addr 4 and addr 5, plus a prefetch pulse at addr 6.
- Aborted write: cmd 0x87, 5 data bits, cs high -> no mem_we; busy falls; the next transaction 0x07 read returns the unchanged old byte 7.
- Reset mid-burst: assert rst_n low during the 2nd data byte of a write -> all outputs 0 immediately; the first byte is written, the second is not.
- Idle noise: toggle sclk/mosi with cs_n high for 20 edges -> no strobes; busy = 0; spi_miso_oe = 0.

Source files
------------

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns host transactions into single-cycle byte read and
// write strobes for a synchronous byte memory. All SPI pins are oversampled in clk.
module spi_mem_bridge #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, CMD, WRITE, FETCH, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic                   sclk_prev_reg;
  logic                   sclk_s, cs_s, mosi_s, rise, fall, last_bit;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]      shift_reg, shift_next, byte_in;
  logic [DATA_W-1:0]      tx_reg, tx_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [DATA_W-1:0]      wdata_reg, wdata_next;
  logic                   we_reg, we_next, re_reg, re_next;
  logic                   busy_reg, busy_next, oe_reg, oe_next;

  // cs_n synchroniser resets to deselected so reset release never looks like a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_reg <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev_reg;
  assign fall     = ~sclk_s & sclk_prev_reg;
  assign last_bit = (bit_cnt_reg == CNT_W'(DATA_W-1));
  assign byte_in  = {shift_reg[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      re_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      oe_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      we_reg      <= we_next;
      re_reg      <= re_next;
      busy_reg    <= busy_next;
      oe_reg      <= oe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    we_next      = 1'b0;
    re_next      = 1'b0;
    busy_next    = busy_reg;
    oe_next      = oe_reg;

    // the address advances in the cycle after each write strobe
    if (we_reg) addr_next = addr_reg + 1'b1;

    if (cs_s && state_reg != IDLE) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      tx_next      = '0;
      busy_next    = 1'b0;
      oe_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!cs_s) begin
            state_next   = CMD;
            bit_cnt_next = '0;
            shift_next   = '0;
            tx_next      = '0;
            busy_next    = 1'b1;
            oe_next      = 1'b1;
          end
        end
        CMD: begin
          if (rise) begin
            shift_next   = byte_in;
            bit_cnt_next = last_bit ? '0 : bit_cnt_reg + 1'b1;
            if (last_bit) begin
              addr_next = byte_in[ADDR_W-1:0];
              if (byte_in[DATA_W-1]) begin
                state_next = WRITE;
              end else begin
                state_next = FETCH;
                re_next    = 1'b1;
              end
            end
          end
        end
        WRITE: begin
          if (rise) begin
            shift_next   = byte_in;
            bit_cnt_next = last_bit ? '0 : bit_cnt_reg + 1'b1;
            if (last_bit) begin
              wdata_next = byte_in;
              we_next    = 1'b1;
            end
          end
        end
        FETCH: begin
          // read data is valid once the strobe cycle has passed
          if (!re_reg) begin
            tx_next    = mem_rdata;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (fall && bit_cnt_reg != '0) tx_next = {tx_reg[DATA_W-2:0], 1'b0};
          if (rise) begin
            bit_cnt_next = last_bit ? '0 : bit_cnt_reg + 1'b1;
            if (last_bit) begin
              addr_next  = addr_reg + 1'b1;
              re_next    = 1'b1;
              state_next = FETCH;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign spi_miso    = tx_reg[DATA_W-1];
  assign spi_miso_oe = oe_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign mem_we      = we_reg;
  assign mem_re      = re_reg;
  assign busy        = busy_reg;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge: SPI host tasks, a 32x8 memory model
// with registered read, a vector table of write/readback transactions and corner cases.
module tb_spi_mem_bridge;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, mem_we, mem_re, busy;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  spi_mem_bridge #(.ADDR_W(5), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model plus strobe logging
  logic [7:0]  mem [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [12:0] we_q [$];
  logic [4:0]  re_q [$];
  int          viol = 0;
  logic        prev_we = 1'b0, prev_re = 1'b0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_q.push_back({mem_addr, mem_wdata});
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_q.push_back(mem_addr);
    end
    if (mem_we && mem_re) viol++;
    if ((mem_we && prev_we) || (mem_re && prev_re)) viol++;
    prev_we = mem_we;
    prev_re = mem_re;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] wcmd;
    logic [7:0] data;
    logic [7:0] rcmd;
    logic [4:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] r0, r1, dummy;
  int         wb, rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cmd bits 6:5 are don't-care, so 0xE0 / 0x60 still address byte 0
    vecs[0] = '{8'h83, 8'hA5, 8'h03, 5'd3,  8'hA5};
    vecs[1] = '{8'hE0, 8'h5C, 8'h60, 5'd0,  8'h5C};
    vecs[2] = '{8'h9F, 8'hFF, 8'h1F, 5'd31, 8'hFF};
    vecs[3] = '{8'hB0, 8'h3C, 8'h30, 5'd16, 8'h3C};
    vecs[4] = '{8'h87, 8'h81, 8'h47, 5'd7,  8'h81};

    repeat (3) @(negedge clk);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset we/re/busy/oe/miso", {27'd0, mem_we, mem_re, busy, spi_miso_oe, spi_miso}, 0);
    chk("reset mem_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) poke(5'(i), 8'(i * 3));
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      wb = we_q.size();
      cs_begin();
      chk($sformatf("v%0d busy/oe on select", v), {30'd0, busy, spi_miso_oe}, 3);
      spi_bits(vecs[v].wcmd, 8, dummy);
      spi_bits(vecs[v].data, 8, dummy);
      cs_end();
      chk($sformatf("v%0d we count", v), we_q.size() - wb, 1);
      if (we_q.size() > wb) begin
        chk($sformatf("v%0d we addr", v), 32'(we_q[wb][12:8]), 32'(vecs[v].exp_addr));
        chk($sformatf("v%0d we data", v), 32'(we_q[wb][7:0]), 32'(vecs[v].exp_rd));
      end
      chk($sformatf("v%0d mem byte", v), 32'(mem[vecs[v].exp_addr]), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d busy/oe/miso after", v), {29'd0, busy, spi_miso_oe, spi_miso}, 0);
      rb = re_q.size();
      cs_begin();
      spi_bits(vecs[v].rcmd, 8, dummy);
      spi_bits(8'h00, 8, r0);
      cs_end();
      chk($sformatf("v%0d readback", v), 32'(r0), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d re count", v), re_q.size() - rb, 2);
      if (re_q.size() > rb) chk($sformatf("v%0d re addr", v), 32'(re_q[rb]), 32'(vecs[v].exp_addr));
    end

    // burst write wrapping 30, 31, 0
    wb = we_q.size();
    cs_begin();
    spi_bits(8'h9E, 8, dummy);
    spi_bits(8'h11, 8, dummy);
    spi_bits(8'h22, 8, dummy);
    spi_bits(8'h33, 8, dummy);
    cs_end();
    chk("wrap we count", we_q.size() - wb, 3);
    if (we_q.size() >= wb + 3) begin
      chk("wrap we0", 32'(we_q[wb]),     32'({5'd30, 8'h11}));
      chk("wrap we1", 32'(we_q[wb + 1]), 32'({5'd31, 8'h22}));
      chk("wrap we2", 32'(we_q[wb + 2]), 32'({5'd0,  8'h33}));
    end
    chk("wrap mem0", 32'(mem[0]), 32'h33);
    chk("wrap final addr", 32'(mem_addr), 1);

    // read burst with prefetch
    poke(5'd4, 8'h5A);
    poke(5'd5, 8'hC3);
    wb = we_q.size();
    rb = re_q.size();
    cs_begin();
    spi_bits(8'h04, 8, dummy);
    spi_bits(8'h00, 8, r0);
    spi_bits(8'h00, 8, r1);
    cs_end();
    chk("burst rd0", 32'(r0), 32'h5A);
    chk("burst rd1", 32'(r1), 32'hC3);
    chk("burst re count", re_q.size() - rb, 3);
    if (re_q.size() >= rb + 3) chk("burst re addrs", 32'({re_q[rb], re_q[rb + 1], re_q[rb + 2]}), 32'({5'd4, 5'd5, 5'd6}));
    chk("burst no we", we_q.size() - wb, 0);

    // aborted write after 5 data bits
    wb = we_q.size();
    cs_begin();
    spi_bits(8'h87, 8, dummy);
    spi_bits(8'hF0, 5, dummy);
    cs_end();
    chk("abort no we", we_q.size() - wb, 0);
    chk("abort busy", 32'(busy), 0);
    cs_begin();
    spi_bits(8'h07, 8, dummy);
    spi_bits(8'h00, 8, r0);
    cs_end();
    chk("abort old byte7", 32'(r0), 32'h81);

    // reset during the 2nd data byte of a write
    poke(5'd13, 8'h77);
    wb = we_q.size();
    cs_begin();
    spi_bits(8'h8C, 8, dummy);
    spi_bits(8'h3C, 8, dummy);
    spi_bits(8'h99, 4, dummy);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid addr/wdata", {mem_addr, mem_wdata}, 0);
    chk("rst mid flags", {27'd0, mem_we, mem_re, busy, spi_miso_oe, spi_miso}, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("rst we count", we_q.size() - wb, 1);
    chk("rst byte12", 32'(mem[12]), 32'h3C);
    chk("rst byte13", 32'(mem[13]), 32'h77);

    // sclk/mosi noise with cs_n high
    wb = we_q.size();
    rb = re_q.size();
    for (int e = 0; e < 20; e++) begin
      spi_mosi = e[1];
      spi_sclk = ~spi_sclk;
      repeat (4) @(negedge clk);
    end
    chk("noise strobes", (we_q.size() - wb) + (re_q.size() - rb), 0);
    chk("noise busy/oe", {30'd0, busy, spi_miso_oe}, 0);
    chk("strobe exclusivity", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
